iir_out_decimator: RTL and testbench

- Output stage placed directly downstream of the 8-bit IIR filter datapath.
- Takes the filter's per-cycle 8-bit signed output samples and averages each non-overlapping block of DEC samples with rounding.
- Produces one decimated sample per block.
- Buffers decimated samples in a small FIFO behind a valid/ready handshake so a stalling consumer does not stall the filter; reports dropped samples with a sticky overflow flag.

---
 rtl/iir_out_decimator.sv | 129 ++++++++++++
 tb/tb_iir_out_decimator.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/iir_out_decimator.sv
// Output stage for the 8-bit IIR filter.
// Each block of DEC valid input samples becomes one sample. That sample is the block
// average, rounded half up. Results wait in a small FIFO behind a valid/ready handshake,
// so a stalling consumer never stalls the filter. A result that arrives while the FIFO
// is full is dropped, and the sticky ovf flag is set.
//
// Ports:
//   CLK       clock, rising edge
//   RST       asynchronous active-low reset
//   din       signed sample from the filter
//   din_vld   din is valid this cycle
//   dout      signed decimated sample at the FIFO head; 0 while the FIFO is empty
//   dout_vld  FIFO is non-empty
//   dout_rdy  consumer accepts dout this cycle
//   fill      FIFO occupancy, 0..FIFO_DEPTH
//   ovf       sticky flag: a decimated sample was dropped
//   clr_ovf   synchronous clear of ovf; a same-cycle drop wins
module iir_out_decimator #(
  parameter int unsigned DW         = 8,
  parameter int unsigned DEC        = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic signed [DW-1:0]          din,
  input  logic                          din_vld,
  output logic signed [DW-1:0]          dout,
  output logic                          dout_vld,
  input  logic                          dout_rdy,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          ovf,
  input  logic                          clr_ovf
);

  localparam int unsigned K    = $clog2(DEC);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned AccW = DW + K;

  // Block accumulator
  logic signed [AccW-1:0] acc_q, acc_d, sum, rounded;
  logic [K-1:0]           cnt_q, cnt_d;
  logic                   blk_done;
  logic [DW-1:0]          result;

  always_comb begin
    sum      = acc_q + $signed({{K{din[DW-1]}}, din});
    rounded  = sum + AccW'(DEC / 2);
    // The block sum of DW-bit samples, shifted right by K, always fits in DW bits.
    result   = DW'(rounded >>> K);
    blk_done = din_vld && (cnt_q == K'(DEC - 1));
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (din_vld) begin
      if (blk_done) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + K'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  // Output FIFO
  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic          ovf_q, ovf_d;
  logic          empty, full, pop, push, drop;

  always_comb begin
    empty = (fill_q == '0);
    full  = (fill_q == (AW + 1)'(FIFO_DEPTH));
    pop   = !empty && dout_rdy;
    // When the FIFO is full, a same-cycle pop frees the slot that the push then writes.
    push  = blk_done && (!full || pop);
    drop  = blk_done && full && !pop;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    fill_d   = fill_q;
    if (push && !pop) begin
      fill_d = fill_q + (AW + 1)'(1);
    end else if (pop && !push) begin
      fill_d = fill_q - (AW + 1)'(1);
    end

    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage has no reset: an entry is read only after it has been written.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= result;
  end

  always_comb begin
    dout_vld = !empty;
    dout     = empty ? '0 : mem_q[rd_ptr_q];
    fill     = fill_q;
    ovf      = ovf_q;
  end

endmodule

// File: tb/tb_iir_out_decimator.sv
module tb_iir_out_decimator;

  localparam int DEC   = 4;
  localparam int DEPTH = 4;

  logic              CLK = 1'b0;
  logic              RST;
  logic signed [7:0] din;
  logic              din_vld;
  logic signed [7:0] dout;
  logic              dout_vld;
  logic              dout_rdy;
  logic [2:0]        fill;
  logic              ovf;
  logic              clr_ovf;

  iir_out_decimator #(.DW(8), .DEC(DEC), .FIFO_DEPTH(DEPTH)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .din      (din),
    .din_vld  (din_vld),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy),
    .fill     (fill),
    .ovf      (ovf),
    .clr_ovf  (clr_ovf)
  );

  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  // Scoreboard and reference model state
  int sb[$];
  int m_sum    = 0;
  int m_cnt    = 0;
  bit pend     = 1'b0;
  int pend_val = 0;
  bit exp_ovf  = 1'b0;

  // Rounded average as a floor division of (sum + DEC/2) by DEC
  function automatic int rnd_avg(input int s);
    int t;
    t = s + DEC / 2;
    if (t >= 0) return t / DEC;
    return -((-t + DEC - 1) / DEC);
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Check outputs mid-cycle, then apply the model for the coming rising edge.
  task automatic tick();
    @(negedge CLK);
    chk("fill", fill, sb.size());
    chk("ovf", ovf, exp_ovf);
    chk("dout_vld", dout_vld, sb.size() != 0);
    if (sb.size() != 0) begin
      chk("dout", dout, sb[0]);
      if (dout_rdy) void'(sb.pop_front());
    end else begin
      chk("dout_idle", dout, 0);
    end
    if (clr_ovf) exp_ovf = 1'b0;
    if (pend) begin
      if (sb.size() < DEPTH) sb.push_back(pend_val);
      else exp_ovf = 1'b1;
      pend = 1'b0;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input int s);
    din     = 8'(s);
    din_vld = 1'b1;
    m_sum  += s;
    m_cnt++;
    if (m_cnt == DEC) begin
      pend     = 1'b1;
      pend_val = rnd_avg(m_sum);
      m_sum    = 0;
      m_cnt    = 0;
    end
    tick();
    din_vld = 1'b0;
  endtask

  // One block into an empty FIFO, then check the head directly.
  task automatic block(input int a, input int b, input int c, input int d, input int exp);
    send(a);
    send(b);
    send(c);
    send(d);
    chk("blk_vld", dout_vld, 1);
    chk("blk_val", dout, exp);
    idle(1);
  endtask

  initial begin
    RST      = 1'b0;
    din      = '0;
    din_vld  = 1'b0;
    dout_rdy = 1'b0;
    clr_ovf  = 1'b0;
    #12;
    chk("rst_vld", dout_vld, 0);
    chk("rst_fill", fill, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_dout", dout, 0);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1;

    // Basic averages and signed rounding
    dout_rdy = 1'b1;
    block(1, 2, 3, 4, 3);
    chk("basic_fill", fill, 0);
    block(-1, -2, -3, -4, -2);
    block(127, 127, 127, 127, 127);
    block(-128, -128, -128, -128, -128);
    block(1, 0, 0, 0, 0);
    block(2, 0, 0, 0, 1);

    // Gapped input: nothing comes out before the fourth valid sample.
    for (int i = 0; i < 3; i++) begin
      send(5);
      idle(3);
      chk("gap_novld", dout_vld, 0);
    end
    send(5);
    chk("gap_val", dout, 5);
    idle(2);

    // Backpressure: five blocks into a 4-deep FIFO drops the fifth.
    dout_rdy = 1'b0;
    for (int k = 1; k <= 5; k++) for (int j = 0; j < DEC; j++) send(k);
    chk("ovf_fill", fill, 4);
    chk("ovf_set", ovf, 1);
    dout_rdy = 1'b1;
    idle(5);
    chk("ovf_drained", fill, 0);
    chk("ovf_sticky", ovf, 1);
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    chk("ovf_clr", ovf, 0);

    // Full with a same-cycle pop: the push is accepted, with no overflow.
    dout_rdy = 1'b0;
    for (int k = 1; k <= 4; k++) for (int j = 0; j < DEC; j++) send(10 * k);
    send(50);
    send(50);
    send(50);
    dout_rdy = 1'b1;
    send(50);
    chk("fullpop_fill", fill, 4);
    chk("fullpop_ovf", ovf, 0);
    idle(5);

    // A drop and clr_ovf in the same cycle: the drop wins.
    dout_rdy = 1'b0;
    for (int k = 1; k <= 4; k++) for (int j = 0; j < DEC; j++) send(k);
    send(6);
    send(6);
    send(6);
    clr_ovf = 1'b1;
    send(6);
    clr_ovf = 1'b0;
    chk("setwins_ovf", ovf, 1);
    dout_rdy = 1'b1;
    idle(5);

    // Mid-block asynchronous reset while the FIFO holds data and ovf is set.
    dout_rdy = 1'b0;
    for (int j = 0; j < DEC; j++) send(7);
    send(9);
    send(9);
    #1 RST = 1'b0;
    #1;
    chk("mrst_vld", dout_vld, 0);
    chk("mrst_fill", fill, 0);
    chk("mrst_ovf", ovf, 0);
    sb.delete();
    m_sum   = 0;
    m_cnt   = 0;
    pend    = 1'b0;
    exp_ovf = 1'b0;
    #1 RST = 1'b1;
    dout_rdy = 1'b1;
    send(4);
    send(4);
    send(4);
    chk("mrst_partial", dout_vld, 0);
    send(4);
    chk("mrst_val", dout, 4);
    idle(3);
    chk("final_fill", fill, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
